// File: rtl/addertree_seq_ctrl.sv
// rtl/addertree_seq_ctrl.sv - sequencing controller for the stage-1 adder-tree (optional ADDERTREE_SEQ_CTRL_PERF_EN)
module addertree_seq_ctrl #(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [PIPE_DEPTH-1:0] stage_en,
  output logic                  acc_en,
  output logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  err_len
`ifdef ADDERTREE_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      acc_cnt;
  logic [PIPE_DEPTH-1:0] v_q;
  logic                  err_q;

  logic                  fire;
  logic                  start_ok;
  logic                  start_bad;
  logic                  last_issue;
  logic                  acc_complete;

  // Handshake decode, valid-bit shifting and accumulator controls
  always_comb begin
    in_ready   = (state_q == RUN);
    busy       = (state_q != IDLE);
    out_valid  = (state_q == DONE);
    err_len    = err_q;
    fire       = in_valid && in_ready;
    start_ok   = (state_q == IDLE) && start && (cfg_len != '0);
    start_bad  = (state_q == IDLE) && start && (cfg_len == '0);
    last_issue = fire && ((issue_cnt + CNT_W'(1)) == len_q);
    // stage 0 loads on a fire; every later stage loads from the previous stage's valid bit
    stage_en   = (v_q << 1) | PIPE_DEPTH'(fire);
    acc_en     = v_q[PIPE_DEPTH-1];
    acc_clr    = acc_en && (acc_cnt == '0);
    // look one acc_en ahead so out_valid rises the cycle after the last accumulate
    acc_complete = (acc_cnt == len_q) ||
                   (acc_en && ((acc_cnt + CNT_W'(1)) == len_q));
  end

  // Next-state logic for the job sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (acc_complete) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Per-stage valid bits; a reset discards every in-flight term
  always_ff @(posedge clk) begin
    if (!reset_n) v_q <= '0;
    else          v_q <= stage_en;
  end

  // Job length capture and issue/accumulate counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q     <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
    end else if (start_ok) begin
      len_q     <= cfg_len;
      issue_cnt <= '0;
      acc_cnt   <= '0;
    end else begin
      if (fire)   issue_cnt <= issue_cnt + CNT_W'(1);
      if (acc_en) acc_cnt   <= acc_cnt + CNT_W'(1);
    end
  end

  // Zero-length start flag, visible for exactly one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= start_bad;
  end

`ifdef ADDERTREE_SEQ_CTRL_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter; the value seen in a cycle includes that cycle if it is busy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= 32'd1;
    end else if ((state_d != IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  // Counter output
  always_comb begin
    perf_cycles = perf_q;
  end
`endif

endmodule
